// File: rtl/lead_norm_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : lead_norm_pipe_if
// Brief    : Operand/result handshake bundle for the lead_norm_pipe
//            normalisation unit (input valid/ready, output valid/ready).
// Revision : 1.0 - initial release
// ============================================================================
interface lead_norm_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] A;
    logic [1:0]       Mode;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] Z;
    logic [CW-1:0]    Cnt;
    logic             AllSame;

    // Block side of the bundle
    modport slave (
        input  InValid, A, Mode, OutReady,
        output InReady, OutValid, Z, Cnt, AllSame
    );

    // Producer/consumer side of the bundle
    modport master (
        output InValid, A, Mode, OutReady,
        input  InReady, OutValid, Z, Cnt, AllSame
    );
endinterface
`default_nettype wire

// File: rtl/lead_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module   : lead_norm_pipe
// Brief    : Two-stage elastic normaliser. Stage 1 counts leading zeros,
//            ones or redundant sign bits; stage 2 left-shifts the operand by
//            that count. Valid/ready flow control, one operand per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module lead_norm_pipe #(
    parameter int WIDTH = 8,
    parameter int SPEED = 1     // 1 = log-depth prefix tree, 0 = ripple chain
) (
    input  wire logic       CLK,
    input  wire logic       RST,
    lead_norm_pipe_if.slave bus
);
    localparam int CW           = $clog2(WIDTH + 1);
    localparam int c_SPEED_FAST = 1;
    localparam int c_LEVELS     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Stage-1 detect signals
    logic             w_ref;
    logic [WIDTH-1:0] w_xor;
    logic [WIDTH-1:0] w_diff;     // 1 where a bit differs from the reference
    logic [WIDTH-1:0] w_nz;
    logic [WIDTH-1:0] w_pre;      // w_pre[i] = no differing bit in [WIDTH-1:i]
    logic [WIDTH-1:0] w_onehot;
    logic             w_all;
    logic [CW-1:0]    w_cnt;

    // Pipeline registers and handshake terms
    logic             r_v1;
    logic [WIDTH-1:0] r_a1;
    logic             r_sgn1;
    logic [CW-1:0]    r_cnt1;
    logic             r_v2;
    logic [WIDTH-1:0] r_z2;
    logic [CW-1:0]    r_cnt2;
    logic             r_all2;
    logic             w_ld1;
    logic             w_ld2;
    logic             w_all1;
    logic [WIDTH-1:0] w_z1;

    // Difference vector. In sign mode the sign bit itself is dropped and a
    // sentinel 1 is appended at the bottom: this shifts the scan window down
    // by one and makes the all-sign case land on WIDTH-1 without an adder.
    always_comb begin
        w_ref  = bus.Mode[1] ? bus.A[WIDTH-1] : bus.Mode[0];
        w_xor  = bus.A ^ {WIDTH{w_ref}};
        w_diff = bus.Mode[1] ? {w_xor[WIDTH-2:0], 1'b1} : w_xor;
    end

    assign w_nz = ~w_diff;

    generate
        if (SPEED == c_SPEED_FAST) begin : g_fast
            logic [WIDTH-1:0] w_lvl;
            // Kogge-Stone suffix-AND from the MSB; vacated top bits pass through
            always_comb begin
                w_lvl = w_nz;
                for (int l = 0; l < c_LEVELS; l++) begin
                    w_lvl = w_lvl & ((w_lvl >> (1 << l)) | ~({WIDTH{1'b1}} >> (1 << l)));
                end
                w_pre = w_lvl;
            end
        end else begin : g_slow
            logic [WIDTH-1:0] w_chain;
            // Ripple suffix-AND from the MSB down
            always_comb begin
                w_chain            = w_nz;
                w_chain[WIDTH-1]   = w_nz[WIDTH-1];
                for (int i = WIDTH - 2; i >= 0; i--) begin
                    w_chain[i] = w_chain[i+1] & w_nz[i];
                end
                w_pre = w_chain;
            end
        end
    endgenerate

    // One-hot first differing bit, then OR-encode its distance from the MSB
    always_comb begin
        w_onehot = w_diff & {1'b1, w_pre[WIDTH-1:1]};
        w_all    = w_pre[0];
        w_cnt    = w_all ? CW'(WIDTH) : '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_onehot[i]) begin
                w_cnt = w_cnt | CW'(WIDTH - 1 - i);
            end
        end
    end

    // Handshake: a stage loads when it is empty or its successor can load
    assign w_ld2       = ~r_v2 | bus.OutReady;
    assign w_ld1       = ~r_v1 | w_ld2;
    assign bus.InReady = w_ld1 & ~RST;

    // Stage 1: capture operand, sign-mode flag and count on accept
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_v1   <= 1'b0;
            r_a1   <= '0;
            r_sgn1 <= 1'b0;
            r_cnt1 <= '0;
        end else if (w_ld1) begin
            r_v1 <= bus.InValid;
            if (bus.InValid) begin
                r_a1   <= bus.A;
                r_sgn1 <= bus.Mode[1];
                r_cnt1 <= w_cnt;
            end
        end
    end

    // Saturation is recognised from the count: WIDTH-1 in sign mode, WIDTH otherwise
    always_comb begin
        w_all1 = r_sgn1 ? (r_cnt1 == CW'(WIDTH - 1)) : (r_cnt1 == CW'(WIDTH));
        w_z1   = r_a1 << r_cnt1;
    end

    // Stage 2: shift result, count and saturation flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_v2   <= 1'b0;
            r_z2   <= '0;
            r_cnt2 <= '0;
            r_all2 <= 1'b0;
        end else if (w_ld2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_z2   <= w_z1;
                r_cnt2 <= r_cnt1;
                r_all2 <= w_all1;
            end
        end
    end

    assign bus.OutValid = r_v2;
    assign bus.Z        = r_z2;
    assign bus.Cnt      = r_cnt2;
    assign bus.AllSame  = r_all2;
endmodule
`default_nettype wire

// File: tb/tb_lead_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_lead_norm_pipe
// Brief    : Directed and randomised checks of lead_norm_pipe at widths
//            2, 8, 13 and 32 sharing one handshake stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lead_norm_pipe;
    localparam int NW = 4;
    localparam int WS [0:NW-1] = '{2, 8, 13, 32};

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a_drv     = '0;
    logic [1:0]  mode      = '0;

    logic        ir_w  [0:NW-1];
    logic        ov_w  [0:NW-1];
    logic        as_w  [0:NW-1];
    logic [31:0] z_w   [0:NW-1];
    logic [7:0]  cnt_w [0:NW-1];

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [1:0]  m;
    } op_t;
    op_t qa[$];

    always #5 clk = ~clk;

    generate
        for (genvar k = 0; k < NW; k++) begin : g_dut
            localparam int W = WS[k];
            lead_norm_pipe_if #(.WIDTH(W)) bus ();
            assign bus.InValid  = in_valid;
            assign bus.A        = a_drv[W-1:0];
            assign bus.Mode     = mode;
            assign bus.OutReady = out_ready;
            lead_norm_pipe #(.WIDTH(W), .SPEED((k == 0 || k == 2) ? 0 : 1)) u_dut (
                .CLK (clk),
                .RST (rst),
                .bus (bus)
            );
            assign ir_w[k]  = bus.InReady;
            assign ov_w[k]  = bus.OutValid;
            assign as_w[k]  = bus.AllSame;
            assign z_w[k]   = 32'(bus.Z);
            assign cnt_w[k] = 8'(bus.Cnt);
        end
    endgenerate

    // Reference: straightforward MSB-first scan
    function automatic void model(input int w, input logic [31:0] a, input logic [1:0] m,
                                  output logic [31:0] z, output logic [7:0] c, output logic s);
        logic [63:0] mask;
        logic [63:0] t;
        logic [31:0] am;
        logic        r;
        int          top;
        bit          hit;
        mask = (64'd1 << w) - 64'd1;
        am   = a & mask[31:0];
        r    = m[1] ? am[w-1] : m[0];
        top  = m[1] ? w - 2 : w - 1;
        c    = '0;
        hit  = 1'b0;
        for (int i = top; i >= 0; i--) begin
            if (!hit) begin
                if (am[i] !== r) hit = 1'b1;
                else             c   = c + 8'd1;
            end
        end
        s = !hit;
        t = ({32'b0, am} << c) & mask;
        z = t[31:0];
    endfunction

    function automatic logic [31:0] rand_a();
        int unsigned sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h1 << $urandom_range(0, 31);
            3:       return ~(32'h1 << $urandom_range(0, 31));
            4:       return 32'hFFFF_FFFF << $urandom_range(0, 31);
            default: return $urandom();
        endcase
    endfunction

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        qa.delete();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        a_drv     = 32'h33;
        @(negedge clk);
        n_vec++; if (ir_w[1] !== 1'b0) begin n_err++; $display("FAIL reset_inready got=%0b exp=0", ir_w[1]); end
        n_vec++; if (ov_w[1] !== 1'b0) begin n_err++; $display("FAIL reset_outvalid got=%0b exp=0", ov_w[1]); end
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (ir_w[1] !== 1'b1) begin n_err++; $display("FAIL post_reset_inready got=%0b exp=1", ir_w[1]); end
        n_vec++;
        if (ov_w[1] !== 1'b0 || z_w[1] !== 32'h0 || cnt_w[1] !== 8'd0 || as_w[1] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs got ov=%0b z=%h cnt=%0d all=%0b exp all zero", ov_w[1], z_w[1], cnt_w[1], as_w[1]);
        end
        @(posedge clk); #1;
    endtask

    // Back-to-back hand-computed width-8 vectors; output i expected exactly 2 cycles after its offer
    task automatic test_directed();
        logic [1:0] tm [0:12] = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd1};
        logic [7:0] ta [0:12] = '{8'h05, 8'hFA, 8'h00, 8'hFF, 8'hFF, 8'h80, 8'hFA, 8'hF0, 8'h01, 8'h00, 8'h40, 8'hC0, 8'h7F};
        logic [7:0] tz [0:12] = '{8'h50, 8'hA0, 8'h00, 8'h00, 8'h80, 8'h80, 8'hA0, 8'h00, 8'h80, 8'h00, 8'h40, 8'h80, 8'h7F};
        logic [7:0] tc [0:12] = '{8'd4, 8'd4, 8'd8, 8'd8, 8'd7, 8'd0, 8'd4, 8'd4, 8'd7, 8'd7, 8'd0, 8'd1, 8'd0};
        logic       ts [0:12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (k < 13) begin
                in_valid = 1'b1;
                a_drv    = {24'h0, ta[k]};
                mode     = tm[k];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (k < 13) begin
                n_vec++; if (ir_w[1] !== 1'b1) begin n_err++; $display("FAIL dir_inready k=%0d got=%0b exp=1", k, ir_w[1]); end
            end
            n_vec++;
            if (ov_w[1] !== (k >= 2)) begin n_err++; $display("FAIL dir_latency k=%0d got ov=%0b exp=%0b", k, ov_w[1], k >= 2); end
            if (k >= 2) begin
                n_vec++;
                if (z_w[1] !== {24'h0, tz[k-2]} || cnt_w[1] !== tc[k-2] || as_w[1] !== ts[k-2]) begin
                    n_err++;
                    $display("FAIL dir_vec%0d got z=%h cnt=%0d all=%0b exp z=%h cnt=%0d all=%0b",
                             k - 2, z_w[1], cnt_w[1], as_w[1], tz[k-2], tc[k-2], ts[k-2]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] ez [0:6] = '{8'h00, 8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'hC0};
        logic [7:0] ec [0:6] = '{8'd0, 8'd0, 8'd7, 8'd7, 8'd7, 8'd6, 8'd6};
        logic       eir[0:6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       eov[0:6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        mode = 2'd0;
        for (int k = 0; k < 8; k++) begin
            in_valid  = (k < 5);
            a_drv     = (k == 0) ? 32'h01 : (k == 1) ? 32'h02 : 32'h03;
            out_ready = (k >= 4);
            @(negedge clk);
            if (k < 7) begin
                if (k < 5) begin
                    n_vec++; if (ir_w[1] !== eir[k]) begin n_err++; $display("FAIL bp_inready k=%0d got=%0b exp=%0b", k, ir_w[1], eir[k]); end
                end
                n_vec++; if (ov_w[1] !== eov[k]) begin n_err++; $display("FAIL bp_outvalid k=%0d got=%0b exp=%0b", k, ov_w[1], eov[k]); end
                if (eov[k]) begin
                    n_vec++;
                    if (z_w[1] !== {24'h0, ez[k]} || cnt_w[1] !== ec[k] || as_w[1] !== 1'b0) begin
                        n_err++;
                        $display("FAIL bp_data k=%0d got z=%h cnt=%0d all=%0b exp z=%h cnt=%0d all=0", k, z_w[1], cnt_w[1], as_w[1], ez[k], ec[k]);
                    end
                end
            end else begin
                n_vec++; if (ov_w[1] !== 1'b0) begin n_err++; $display("FAIL bp_drained got ov=%0b exp=0", ov_w[1]); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midflight();
        mode      = 2'd0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a_drv     = 32'h11;
        @(posedge clk); #1;
        a_drv = 32'h22;
        @(posedge clk); #1;
        rst   = 1'b1;
        a_drv = 32'h44;
        @(negedge clk);
        n_vec++; if (ov_w[1] !== 1'b1) begin n_err++; $display("FAIL mid_full got ov=%0b exp=1", ov_w[1]); end
        n_vec++; if (ir_w[1] !== 1'b0) begin n_err++; $display("FAIL mid_rst_inready got=%0b exp=0", ir_w[1]); end
        @(posedge clk); #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++;
            if (ov_w[1] !== 1'b0 || z_w[1] !== 32'h0 || cnt_w[1] !== 8'd0 || as_w[1] !== 1'b0) begin
                n_err++;
                $display("FAIL mid_stale k=%0d got ov=%0b z=%h cnt=%0d all=%0b exp all zero", k, ov_w[1], z_w[1], cnt_w[1], as_w[1]);
            end
            if (k == 0) begin
                n_vec++; if (ir_w[1] !== 1'b1) begin n_err++; $display("FAIL mid_after_inready got=%0b exp=1", ir_w[1]); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_streaming();
        op_t         op;
        logic [31:0] ez;
        logic [7:0]  ec;
        logic        es;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 102; k++) begin
            in_valid = (k < 100);
            a_drv    = rand_a();
            mode     = 2'($urandom_range(0, 3));
            @(negedge clk);
            if (k < 100) begin
                n_vec++; if (ir_w[1] !== 1'b1) begin n_err++; $display("FAIL stream_inready k=%0d got=%0b exp=1", k, ir_w[1]); end
            end
            n_vec++; if (ov_w[1] !== (k >= 2)) begin n_err++; $display("FAIL stream_outvalid k=%0d got=%0b exp=%0b", k, ov_w[1], k >= 2); end
            if (ov_w[1] === 1'b1 && qa.size() > 0) begin
                op = qa.pop_front();
                for (int w = 0; w < NW; w++) begin
                    model(WS[w], op.a, op.m, ez, ec, es);
                    n_vec++;
                    if (ov_w[w] !== 1'b1 || z_w[w] !== ez || cnt_w[w] !== ec || as_w[w] !== es) begin
                        n_err++;
                        $display("FAIL stream_w%0d a=%h m=%0d got ov=%0b z=%h cnt=%0d all=%0b exp ov=1 z=%h cnt=%0d all=%0b",
                                 WS[w], op.a, op.m, ov_w[w], z_w[w], cnt_w[w], as_w[w], ez, ec, es);
                    end
                end
            end
            if (in_valid && ir_w[1] === 1'b1) qa.push_back('{a: a_drv, m: mode});
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random_stall();
        op_t         op;
        logic [31:0] ez;
        logic [7:0]  ec;
        logic        es;
        int          n_acc;
        int          cyc;
        int          occ;
        bit          acc_prev;
        do_reset();
        n_acc    = 0;
        cyc      = 0;
        acc_prev = 1'b0;
        while (n_acc < 10000 && cyc < 60000) begin
            if (!in_valid || acc_prev) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a_drv    = rand_a();
                mode     = 2'($urandom_range(0, 3));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            occ = qa.size();
            n_vec++;
            if (ir_w[1] !== ((occ < 2) || out_ready)) begin
                n_err++;
                $display("FAIL rnd_inready cyc=%0d occ=%0d or=%0b got=%0b exp=%0b", cyc, occ, out_ready, ir_w[1], (occ < 2) || out_ready);
            end
            if (ov_w[1] === 1'b1 && out_ready) begin
                n_vec++;
                if (occ == 0) begin
                    n_err++;
                    $display("FAIL rnd_spurious cyc=%0d got ov=1 exp no pending operand", cyc);
                end else begin
                    op = qa.pop_front();
                    for (int w = 0; w < NW; w++) begin
                        model(WS[w], op.a, op.m, ez, ec, es);
                        n_vec++;
                        if (ov_w[w] !== 1'b1 || z_w[w] !== ez || cnt_w[w] !== ec || as_w[w] !== es) begin
                            n_err++;
                            $display("FAIL rnd_w%0d a=%h m=%0d got ov=%0b z=%h cnt=%0d all=%0b exp ov=1 z=%h cnt=%0d all=%0b",
                                     WS[w], op.a, op.m, ov_w[w], z_w[w], cnt_w[w], as_w[w], ez, ec, es);
                        end
                    end
                end
            end
            acc_prev = in_valid && (ir_w[1] === 1'b1);
            if (acc_prev) begin
                qa.push_back('{a: a_drv, m: mode});
                n_acc++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (n_acc < 10000) begin n_err++; $display("FAIL rnd_timeout got=%0d accepted exp=10000", n_acc); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ov_w[1] === 1'b1 && qa.size() > 0) begin
                op = qa.pop_front();
                for (int w = 0; w < NW; w++) begin
                    model(WS[w], op.a, op.m, ez, ec, es);
                    n_vec++;
                    if (z_w[w] !== ez || cnt_w[w] !== ec || as_w[w] !== es) begin
                        n_err++;
                        $display("FAIL drain_w%0d got z=%h cnt=%0d all=%0b exp z=%h cnt=%0d all=%0b",
                                 WS[w], z_w[w], cnt_w[w], as_w[w], ez, ec, es);
                    end
                end
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if (qa.size() != 0) begin n_err++; $display("FAIL drain_empty got=%0d pending exp=0", qa.size()); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midflight();
        test_streaming();
        test_random_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
